mem_port_arbiter: RTL

Shares one single-ported main-memory interface between the instruction-cache line-fill engine and the data-cache/uncached data path of the pipelined OTTER core. Instruction requests are serviced as fixed-length line bursts and data requests as single-word transfers. Each transfer is sequenced through a small FSM and returns data to the requester with per-word valid strobes. It sits between the L1 caches and the main memory model.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_grant.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// requester identities and the MEM_SIZE encodings.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    I_BURST,
    D_XFER
  } arb_state_e;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // The unused encoding 3 is forwarded as a word access so memory never sees it.
  function automatic logic [1:0] legal_size(input logic [1:0] size);
    case (size)
      SIZE_BYTE, SIZE_HALF, SIZE_WORD: return size;
      default:                         return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Picks which requester is served next. With ARB_ROUND_ROBIN_EN a last-grant
// register makes ties alternate; otherwise the data side always wins ties.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       take,
  output logic       grant_valid,
  output requester_e grant_who
);

  requester_e tie_winner;

`ifdef ARB_ROUND_ROBIN_EN
  requester_e last_grant;

  // Resetting to the instruction side hands the very first tie to data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_I;
    end else if (take) begin
      last_grant <= grant_who;
    end
  end

  assign tie_winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
`else
  logic unused_rr_inputs;

  assign unused_rr_inputs = clk ^ rst_n ^ take;
  assign tie_winner       = REQ_D;
`endif

  always_comb begin
    grant_valid = i_req | d_req;
    grant_who   = REQ_D;
    if (i_req && d_req) begin
      grant_who = tie_winner;
    end else if (i_req) begin
      grant_who = REQ_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-cache line-fill engine (line bursts)
// and the data path (single words). Define ARB_ROUND_ROBIN_EN to alternate ties.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  ADDR_W     = 32,
  parameter int  DATA_W     = 32,
  parameter int  LINE_WORDS = 8,
  localparam int WORD_W     = $clog2(LINE_WORDS)
) (
  input  logic              mem_clk,
  input  logic              mem_rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_valid,
  output logic [WORD_W-1:0] i_word,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  input  logic              d_sign,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_sign,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int                LINE_OFF  = WORD_W + 2;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  arb_state_e        state;
  logic [WORD_W-1:0] word_cnt;
  logic              grant_valid;
  logic              grant_take;
  requester_e        grant_who;
  logic              burst_ack;
  logic              xfer_ack;
  logic              unused_line_offset;

  assign unused_line_offset = ^i_addr[LINE_OFF-1:0];
  assign grant_take         = (state == IDLE) && grant_valid;

  mem_arb_grant u_grant (
    .clk         (mem_clk),
    .rst_n       (mem_rst_n),
    .i_req       (i_req),
    .d_req       (d_req),
    .take        (grant_take),
    .grant_valid (grant_valid),
    .grant_who   (grant_who)
  );

  assign burst_ack = (state == I_BURST) && mem_ack;
  assign xfer_ack  = (state == D_XFER) && mem_ack;

  // Strobes ride on MEM_ACK in the same cycle; data is zeroed when not valid.
  assign i_valid = burst_ack;
  assign i_done  = burst_ack && (word_cnt == LAST_WORD);
  assign i_word  = word_cnt;
  assign i_data  = burst_ack ? mem_rdata : '0;
  assign d_valid = xfer_ack;
  assign d_rdata = xfer_ack ? mem_rdata : '0;

  // Request fields are captured at grant, so requesters may change them afterwards.
  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state     <= IDLE;
      word_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= SIZE_BYTE;
      mem_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            mem_req  <= 1'b1;
            word_cnt <= '0;
            if (grant_who == REQ_I) begin
              state     <= I_BURST;
              mem_we    <= 1'b0;
              mem_addr  <= {i_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
              mem_wdata <= '0;
              mem_size  <= SIZE_WORD;
              mem_sign  <= 1'b0;
            end else begin
              state     <= D_XFER;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_size  <= legal_size(d_size);
              mem_sign  <= d_sign;
            end
          end
        end

        I_BURST: begin
          if (mem_ack) begin
            word_cnt <= word_cnt + WORD_W'(1);
            mem_addr <= mem_addr + ADDR_W'(4);
            if (word_cnt == LAST_WORD) begin
              state     <= IDLE;
              mem_req   <= 1'b0;
              mem_addr  <= '0;
              mem_size  <= SIZE_BYTE;
            end
          end
        end

        D_XFER: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= SIZE_BYTE;
            mem_sign  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
